// File: rtl/timer_scheduler.sv
// Round-robin scheduler that lends one shared 100 ms tick timer to NREQ requesters.
// Each owner gets a countdown of its requested ticks, ending in a one-cycle done pulse.
module timer_scheduler #(
  parameter int unsigned NREQ = 4,
  parameter int unsigned DW   = 4
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [NREQ-1:0]    req,
  input  logic [NREQ*DW-1:0] dly,
  input  logic [NREQ-1:0]    abort,
  output logic               timer_enable,
  output logic               timer_clr_n,
  input  logic               timer_timeout,
  output logic [NREQ-1:0]    grant,
  output logic [NREQ-1:0]    done,
  output logic               busy
);

  localparam int unsigned PW = (NREQ > 1) ? $clog2(NREQ) : 1;
  localparam int unsigned CW = PW + 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    RUN  = 2'd2,
    DONE = 2'd3
  } state_t;

  state_t          state_q;
  logic [PW-1:0]   ptr_q;
  logic [PW-1:0]   owner_q;
  logic [DW-1:0]   rem_q;
  logic [NREQ-1:0] grant_q;
  logic [NREQ-1:0] done_q;
  logic            busy_q;
  logic            en_q;
  logic            clr_n_q;

  logic [PW-1:0]   ptr_d;
  logic [PW-1:0]   win_idx;
  logic            win_vld;
  logic [DW-1:0]   win_dly;
  logic [CW-1:0]   cand;
  logic            abort_hit;
  logic [DW-1:0]   dly_a [NREQ];

  // Unpack the flat delay bus into one entry per requester.
  always_comb begin
    for (int i = 0; i < int'(NREQ); i++) begin
      dly_a[i] = dly[i*DW +: DW];
    end
  end

  // Round-robin search from ptr_q; walking the offsets downward leaves the closest hit.
  always_comb begin
    win_vld = 1'b0;
    win_idx = '0;
    cand    = '0;
    for (int k = int'(NREQ) - 1; k >= 0; k--) begin
      cand = CW'(ptr_q) + CW'(k);
      if (cand >= CW'(NREQ)) begin
        cand = cand - CW'(NREQ);
      end
      if (req[PW'(cand)]) begin
        win_vld = 1'b1;
        win_idx = PW'(cand);
      end
    end
  end

  assign win_dly   = dly_a[win_idx];
  assign abort_hit = |(abort & grant_q);
  assign ptr_d     = (owner_q == PW'(NREQ - 1)) ? '0 : owner_q + PW'(1);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      ptr_q   <= '0;
      owner_q <= '0;
      rem_q   <= '0;
      grant_q <= '0;
      done_q  <= '0;
      busy_q  <= 1'b0;
      en_q    <= 1'b0;
      clr_n_q <= 1'b1;
    end else begin
      done_q <= '0;
      case (state_q)
        IDLE: begin
          if (win_vld) begin
            state_q <= LOAD;
            owner_q <= win_idx;
            grant_q <= NREQ'(1) << win_idx;
            rem_q   <= win_dly;
            busy_q  <= 1'b1;
            en_q    <= 1'b0;
            clr_n_q <= 1'b0;
          end
        end
        LOAD: begin
          if (abort_hit) begin
            state_q <= IDLE;
            grant_q <= '0;
            ptr_q   <= ptr_d;
            busy_q  <= 1'b0;
            en_q    <= 1'b0;
            clr_n_q <= 1'b1;
          end else if (rem_q == '0) begin
            state_q <= DONE;
            done_q  <= grant_q;
            en_q    <= 1'b0;
            clr_n_q <= 1'b1;
          end else begin
            state_q <= RUN;
            en_q    <= 1'b1;
            clr_n_q <= 1'b1;
          end
        end
        RUN: begin
          // Abort outranks a coincident final tick: no done pulse.
          if (abort_hit) begin
            state_q <= IDLE;
            grant_q <= '0;
            ptr_q   <= ptr_d;
            busy_q  <= 1'b0;
            en_q    <= 1'b0;
          end else if (timer_timeout && (rem_q != '0)) begin
            rem_q <= rem_q - DW'(1);
            if (rem_q == DW'(1)) begin
              state_q <= DONE;
              done_q  <= grant_q;
              en_q    <= 1'b0;
            end
          end
        end
        DONE: begin
          state_q <= IDLE;
          grant_q <= '0;
          ptr_q   <= ptr_d;
          busy_q  <= 1'b0;
          en_q    <= 1'b0;
          clr_n_q <= 1'b1;
        end
        default: begin
          state_q <= IDLE;
          grant_q <= '0;
          busy_q  <= 1'b0;
          en_q    <= 1'b0;
          clr_n_q <= 1'b1;
        end
      endcase
    end
  end

  assign grant        = grant_q;
  assign done         = done_q;
  assign busy         = busy_q;
  assign timer_enable = en_q;
  assign timer_clr_n  = clr_n_q;

endmodule

// File: tb/tb_timer_scheduler.sv
// Directed bench for timer_scheduler: round-robin order, countdown latency, zero delay,
// abort handling, abort/timeout collision and asynchronous reset.
module tb_timer_scheduler;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [3:0]  req = '0;
  logic [15:0] dly = '0;
  logic [3:0]  abort = '0;
  logic        timer_timeout = 1'b0;
  logic        timer_enable;
  logic        timer_clr_n;
  logic [3:0]  grant;
  logic [3:0]  done;
  logic        busy;

  int checks = 0;
  int errors = 0;

  timer_scheduler #(.NREQ(4), .DW(4)) dut (
    .clk           (clk),
    .rst           (rst),
    .req           (req),
    .dly           (dly),
    .abort         (abort),
    .timer_enable  (timer_enable),
    .timer_clr_n   (timer_clr_n),
    .timer_timeout (timer_timeout),
    .grant         (grant),
    .done          (done),
    .busy          (busy)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
    end
  endtask

  initial begin
    // Reset state held while rst is high.
    step();
    step();
    chk("rst_grant", 32'(grant), 32'h0);
    chk("rst_done", 32'(done), 32'h0);
    chk("rst_busy", 32'(busy), 32'h0);
    chk("rst_en", 32'(timer_enable), 32'h0);
    chk("rst_clrn", 32'(timer_clr_n), 32'h1);
    rst = 1'b0;
    step();

    // Round-robin with all requesters, delay 1 each.
    req = 4'b1111;
    dly = 16'h1111;
    for (int g = 0; g < 5; g++) begin
      step();
      chk("rr_grant", 32'(grant), 32'(4'b0001 << (g % 4)));
      chk("rr_clrn_load", 32'(timer_clr_n), 32'h0);
      step();
      chk("rr_en_run", 32'(timer_enable), 32'h1);
      timer_timeout = 1'b1;
      step();
      timer_timeout = 1'b0;
      chk("rr_done", 32'(done), 32'(4'b0001 << (g % 4)));
      chk("rr_en_done", 32'(timer_enable), 32'h0);
      step();
      chk("rr_idle_grant", 32'(grant), 32'h0);
      chk("rr_idle_busy", 32'(busy), 32'h0);
    end
    req = 4'b0000;
    step();

    // Single request, delay 3; ticks during IDLE/LOAD must be ignored.
    req = 4'b0001;
    dly = 16'h7F23;
    timer_timeout = 1'b1;
    step();
    chk("s_grant", 32'(grant), 32'h1);
    chk("s_clrn_low", 32'(timer_clr_n), 32'h0);
    chk("s_en_load", 32'(timer_enable), 32'h0);
    chk("s_busy", 32'(busy), 32'h1);
    step();
    timer_timeout = 1'b0;
    chk("s_clrn_high", 32'(timer_clr_n), 32'h1);
    chk("s_en_run", 32'(timer_enable), 32'h1);
    for (int t = 1; t <= 3; t++) begin
      repeat (4) step();
      timer_timeout = 1'b1;
      step();
      timer_timeout = 1'b0;
      if (t < 3) begin
        chk("s_no_early_done", 32'(done), 32'h0);
        chk("s_en_mid", 32'(timer_enable), 32'h1);
      end
    end
    chk("s_done", 32'(done), 32'h1);
    chk("s_en_done", 32'(timer_enable), 32'h0);
    req = 4'b0000;
    step();
    chk("s_idle_grant", 32'(grant), 32'h0);
    chk("s_idle_busy", 32'(busy), 32'h0);
    chk("s_idle_done", 32'(done), 32'h0);

    // Zero delay on requester 2.
    req = 4'b0100;
    dly = 16'h7023;
    step();
    chk("z_grant", 32'(grant), 32'h4);
    chk("z_en_load", 32'(timer_enable), 32'h0);
    step();
    chk("z_done", 32'(done), 32'h4);
    chk("z_en_done", 32'(timer_enable), 32'h0);
    req = 4'b0000;
    step();
    chk("z_idle_grant", 32'(grant), 32'h0);
    chk("z_en_idle", 32'(timer_enable), 32'h0);

    // Abort of owner 1 after two ticks; foreign abort ignored.
    req = 4'b0010;
    dly = 16'h7055;
    step();
    chk("a_grant", 32'(grant), 32'h2);
    step();
    for (int t = 0; t < 2; t++) begin
      step();
      timer_timeout = 1'b1;
      step();
      timer_timeout = 1'b0;
    end
    abort = 4'b1000;
    step();
    abort = 4'b0000;
    chk("a_foreign_grant", 32'(grant), 32'h2);
    chk("a_foreign_en", 32'(timer_enable), 32'h1);
    abort = 4'b0010;
    step();
    abort = 4'b0000;
    req = 4'b0000;
    chk("a_grant_clr", 32'(grant), 32'h0);
    chk("a_busy", 32'(busy), 32'h0);
    chk("a_en", 32'(timer_enable), 32'h0);
    chk("a_no_done", 32'(done), 32'h0);
    step();
    chk("a_no_done_late", 32'(done), 32'h0);
    // Pointer now 2: among {0,1,3} requester 3 wins.
    req = 4'b1011;
    dly = 16'h0055;
    step();
    chk("a_ptr_grant", 32'(grant), 32'h8);
    step();
    chk("a_ptr_done", 32'(done), 32'h8);
    req = 4'b0000;
    step();

    // Abort collides with the final tick.
    req = 4'b0001;
    dly = 16'h0051;
    step();
    chk("c_grant", 32'(grant), 32'h1);
    step();
    timer_timeout = 1'b1;
    abort = 4'b0001;
    step();
    timer_timeout = 1'b0;
    abort = 4'b0000;
    req = 4'b0000;
    chk("c_no_done", 32'(done), 32'h0);
    chk("c_grant_clr", 32'(grant), 32'h0);
    chk("c_busy", 32'(busy), 32'h0);
    step();
    chk("c_no_done_late", 32'(done), 32'h0);

    // Reset mid-RUN with four ticks remaining (owner 1, delay 6).
    req = 4'b0010;
    dly = 16'h0060;
    step();
    chk("r_grant", 32'(grant), 32'h2);
    step();
    for (int t = 0; t < 2; t++) begin
      timer_timeout = 1'b1;
      step();
      timer_timeout = 1'b0;
    end
    chk("r_en_before", 32'(timer_enable), 32'h1);
    #2;
    rst = 1'b1;
    #1;
    chk("r_en_async", 32'(timer_enable), 32'h0);
    chk("r_grant_async", 32'(grant), 32'h0);
    chk("r_busy_async", 32'(busy), 32'h0);
    chk("r_clrn_async", 32'(timer_clr_n), 32'h1);
    req = 4'b0000;
    step();
    chk("r_done_hold", 32'(done), 32'h0);
    rst = 1'b0;
    req = 4'b1000;
    dly = 16'h4060;
    step();
    chk("r2_grant", 32'(grant), 32'h8);
    chk("r2_clrn", 32'(timer_clr_n), 32'h0);
    step();
    chk("r2_en", 32'(timer_enable), 32'h1);
    timer_timeout = 1'b1;
    for (int t = 0; t < 3; t++) begin
      step();
      chk("r2_no_early_done", 32'(done), 32'h0);
    end
    step();
    timer_timeout = 1'b0;
    chk("r2_done", 32'(done), 32'h8);
    req = 4'b0000;
    step();
    chk("r2_idle_grant", 32'(grant), 32'h0);

    // After reset the pointer restarts at requester 0.
    req = 4'b0100;
    dly = 16'h0000;
    step();
    chk("p_grant2", 32'(grant), 32'h4);
    step();
    req = 4'b0000;
    step();
    #1;
    rst = 1'b1;
    #3;
    rst = 1'b0;
    req = 4'b1111;
    step();
    chk("p_grant0", 32'(grant), 32'h1);
    step();
    chk("p_done0", 32'(done), 32'h1);
    req = 4'b0000;
    step();
    chk("p_idle", 32'(busy), 32'h0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/timer_scheduler.md
TIMER_SCHEDULER -- requirements
Module: timer_scheduler

Interface
REQ-001 Parameter NREQ, default 4, number of requesters (2..8).
REQ-002 Parameter DW, default 4, width of each requested delay, in 100 ms units.
REQ-003 Port clk  input  1  single clock; all state updates on its rising edge.
REQ-004 Port rst  input  1  asynchronous, active-high reset.
REQ-005 Port req  input  NREQ  per-requester level request; held until that requester's done pulse or abort.
REQ-006 Port dly  input  NREQ*DW  packed delays; requester i uses bits [i*DW +: DW]; sampled only at grant.
REQ-007 Port abort  input  NREQ  per-requester cancel; only the currently granted bit has effect.
REQ-008 Port timer_enable  output  1  enable to the 100 ms tick timer.
REQ-009 Port timer_clr_n  output  1  active-low synchronous clear to the tick timer.
REQ-010 Port timer_timeout  input  1  one-cycle tick from the timer, one per elapsed 100 ms.
REQ-011 Port grant  output  NREQ  one-hot owner of the timer; all zero when idle.
REQ-012 Port done  output  NREQ  one-cycle pulse to the owner when its delay expires.
REQ-013 Port busy  output  1  high in every state except IDLE.

Function
REQ-014 The FSM SHALL have exactly four states: IDLE, LOAD, RUN and DONE.
REQ-015 IDLE: if any req bit is set, pick a winner round-robin, starting the search at index ptr and wrapping modulo NREQ.
REQ-016 IDLE exit: latch the winner into grant, latch dly for that requester into remaining, and move to LOAD.
REQ-017 LOAD lasts exactly one cycle: timer_clr_n=0, timer_enable=0.
REQ-018 LOAD exit: go to DONE if remaining==0, otherwise go to RUN.
REQ-019 RUN: timer_enable=1 and timer_clr_n=1.
REQ-020 RUN: each cycle with timer_timeout=1 SHALL decrement remaining by 1.
REQ-021 RUN: a timeout seen while remaining==1 SHALL move the FSM to DONE.
REQ-022 DONE lasts one cycle: done[owner]=1, timer_enable=0, then ptr=(owner+1) mod NREQ and grant cleared on the transition to IDLE.
REQ-023 Total latency, remaining=D>0: done SHALL assert 1 cycle after the cycle carrying the D-th timeout.
REQ-024 Total latency, D=0: done SHALL assert 2 cycles after the grant cycle (IDLE->LOAD->DONE).
REQ-025 Abort: abort[owner]=1 in LOAD or RUN SHALL move the FSM to IDLE on the next edge with no done pulse.
REQ-026 Abort: grant cleared and ptr advanced as in DONE; timer_enable low from that edge.
REQ-027 Simultaneous events: abort[owner] and the final timeout in the same cycle -- abort wins, no done pulse.
REQ-028 Abort bits of non-owners SHALL be ignored.
REQ-029 Dropped request: owner deasserting req mid-RUN is not an abort; the sequence completes and done still pulses.
REQ-030 req sampled during DONE SHALL NOT start a new grant in that cycle; arbitration occurs only in IDLE.
REQ-031 Each grant SHALL cost at least one IDLE cycle.
REQ-032 remaining SHALL be DW bits wide and SHALL never underflow; timeouts outside RUN are ignored.
REQ-033 grant SHALL be one-hot or zero at all times.
REQ-034 done SHALL be zero outside DONE.
REQ-035 All outputs SHALL be registered, or decoded from state registers only, with no combinational path from input to output.

Reset
REQ-036 While rst=1, the block SHALL asynchronously hold these values:
- state=IDLE, ptr=0, remaining=0
- grant=0, done=0, busy=0
- timer_enable=0, timer_clr_n=1
REQ-037 Reset mid-RUN SHALL drop timer_enable in the same cycle rst rises, without producing a done pulse.
REQ-038 After rst falls, the first arbitration SHALL favour requester 0.

Verification
REQ-039 Single request: req=0001, dly0=3, timeouts every 5 cycles.
- grant=0001 in LOAD; timer_clr_n low for 1 cycle.
- done[0] 1 cycle after the 3rd timeout; then grant=0000, busy=0.
REQ-040 Round-robin: req=1111 held continuously, all delays=1.
- grants in order 0001, 0010, 0100, 1000, 0001.
- each done precedes the next grant by exactly 1 IDLE cycle.
REQ-041 Zero delay: req=0100, dly2=0.
- done[2] 2 cycles after grant; timer_enable never asserted.
REQ-042 Abort: req=0010, dly1=5, abort[1] pulsed after 2 timeouts.
- no done pulse; grant=0000 next cycle; ptr=2.
- abort[3] while owner=1 has no effect.
REQ-043 Abort/final-timeout collision: dly0=1, abort[0] in the same cycle as the 1st timeout.
- no done pulse; return to IDLE.
REQ-044 Reset mid-run: rst=1 during RUN with remaining=4.
- outputs take reset values immediately.
- next req=1000 after release runs a full 4-state sequence with a correct done.
